ras_restore_q: RTL and testbench
================================

// Module: ras_restore_q
// PURPOSE
//  In-order checkpoint queue for the RAS. pc_gen enqueues the RAS {idx,cnt} after each predicted control
//  instruction and tags that instruction with the returned queue pointer. On mispredict, the saved
//  checkpoint is read and driven one cycle later as the RAS update (update_valid/ras_idx/ras_cnt).
//  Younger entries are squashed. Entries retire in order when their instruction resolves/commits.
// PARAMETERS
//  DEPTH      16  number of checkpoint entries (power of 2, >=2)
//  RAS_IDX_W  3   RAS index width (matches corep::ras_idx_t)
//  RAS_CNT_W  4   RAS count width (matches corep::ras_cnt_t)
//  PTR_W      $clog2(DEPTH)  derived entry-tag width; internal pointers are PTR_W+1 (wrap bit)
// PORTS
//  CLK              in   1          clock, all state on posedge
//  RST              in   1          asynchronous, active-high reset
//  enq_valid        in   1          pc_gen pushes a checkpoint
//  enq_ras_idx      in   RAS_IDX_W  RAS index after the instruction's own push/pop
//  enq_ras_cnt      in   RAS_CNT_W  RAS count after the instruction's own push/pop
//  enq_ready        out  1          queue can accept this cycle
//  enq_tag          out  PTR_W      slot written by this enq (tail low bits), valid with enq_valid&enq_ready
//  deq_valid        in   1          oldest checkpoint's instruction retired
//  restore_valid    in   1          mispredict: restore RAS to checkpoint restore_tag
//  restore_tag      in   PTR_W      tag of mispredicting instruction
//  flush_valid      in   1          full pipeline flush: empty queue, no RAS update
//  update_valid     out  1          RAS restore strobe (to ras update port)
//  update_ras_idx   out  RAS_IDX_W  restored index
//  update_ras_cnt   out  RAS_CNT_W  restored count
//  occupancy        out  PTR_W+1    live entries, 0..DEPTH
//  err_sticky       out  1          set on illegal deq/restore, cleared only by RST
// BEHAVIOUR
//  Reset: head=tail=0, all entries 0. Outputs: enq_ready=1, enq_tag=0, update_valid=0,
//   update_ras_idx=0, update_ras_cnt=0, occupancy=0, err_sticky=0. Reset mid-operation discards
//   everything, including a restore in flight; the next edge never shows update_valid.
//  Pointers: head/tail are PTR_W+1 bits. empty: head==tail. full: low bits equal, MSB differs.
//   occupancy=tail-head, modulo 2^(PTR_W+1).
//  enq_ready = ~full & ~restore_valid & ~flush_valid, from registered state. No same-cycle
//   deq bypass when full. Accepted enq writes entry[tail[PTR_W-1:0]] and increments tail.
//  deq: if empty, ignored and err_sticky<=1. Otherwise head increments.
//  restore is legal when the tag is live, i.e. (restore_tag - head_low) mod DEPTH < occupancy.
//  Legal restore: update_* <= entry[restore_tag], update_valid<=1 next cycle (1-cycle latency).
//   Also tail <= {ptr of restore_tag}+1, which keeps the mispredicting entry and squashes younger ones.
//   The tag's wrap bit is rebuilt from head: head + ((restore_tag-head_low) mod DEPTH).
//  Illegal restore: no update and no pointer change; err_sticky<=1.
//  update_valid is a single-cycle pulse. It deasserts the cycle after unless another restore arrives.
//  Priority: flush > restore > enq. flush: head<=tail (empty), with no update; a pending update_valid pulse
//   already registered still appears. Enq cannot fire with restore or flush (enq_ready=0).
//  deq+restore same cycle: both apply. Legality is checked against pre-deq head.
//   Restore of the retiring entry yields update_valid and an empty queue (head=tail=tag+1).
//  deq+flush same cycle: flush wins, queue empty, no error.
//  Back-to-back restores: each legal one produces its own update the next cycle; the later one uses the
//   post-squash tail.
// TESTING
//  1 reset: RST pulse mid-stream with 5 entries -> occupancy=0, enq_ready=1, update_valid=0, enq_tag=0.
//  2 fill: 16 enq idx=i%8,cnt=i -> tags 0..15, enq_ready=0 at occupancy=16. deq+enq same cycle
//   when full -> enq rejected.
//  3 restore: enq 6 entries, restore_tag=2 -> next cycle update_valid=1, idx=2, cnt=2.
//   occupancy=3, next enq_tag=3.
//  4 wrap: 14 enq/14 deq, then 6 enq (tags 14,15,0..3); restore_tag=1 -> correct entry, occupancy=4.
//   restore_tag=5 -> ignored, err_sticky=1.
//  5 simultaneous: occupancy=1 with head tag 7; deq+restore_tag=7 -> update from entry 7, occupancy=0.
//   flush+restore -> no update, empty.
//  6 errors: deq when empty -> err_sticky=1, pointers unchanged. Random enq/deq/restore vs model, 10k cycles.

Source files
------------

// File: rtl/ras_restore_q.sv
// rtl/ras_restore_q.sv - in-order RAS checkpoint queue with mispredict restore and squash
module ras_restore_q #(
   parameter  int DEPTH     = 16,
   parameter  int RAS_IDX_W = 3,
   parameter  int RAS_CNT_W = 4,
   localparam int PTR_W     = $clog2(DEPTH)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 enq_valid,
   input  logic [RAS_IDX_W-1:0] enq_ras_idx,
   input  logic [RAS_CNT_W-1:0] enq_ras_cnt,
   output logic                 enq_ready,
   output logic [PTR_W-1:0]     enq_tag,
   input  logic                 deq_valid,
   input  logic                 restore_valid,
   input  logic [PTR_W-1:0]     restore_tag,
   input  logic                 flush_valid,
   output logic                 update_valid,
   output logic [RAS_IDX_W-1:0] update_ras_idx,
   output logic [RAS_CNT_W-1:0] update_ras_cnt,
   output logic [PTR_W:0]       occupancy,
   output logic                 err_sticky
);

   localparam logic [PTR_W:0] PTR_ONE = 1;

   logic [PTR_W:0]         head_q, head_d, tail_q, tail_d;
   logic [RAS_IDX_W-1:0]   idx_q [DEPTH];
   logic [RAS_CNT_W-1:0]   cnt_q [DEPTH];
   logic                   upd_v_q, upd_v_d;
   logic [RAS_IDX_W-1:0]   upd_idx_q, upd_idx_d;
   logic [RAS_CNT_W-1:0]   upd_cnt_q, upd_cnt_d;
   logic                   err_q, err_d;

   logic                   empty, full, enq_fire, rs_legal;
   logic [PTR_W-1:0]       rs_dist;
   logic [PTR_W:0]         occ, rs_ptr;

   assign occ      = tail_q - head_q;
   assign empty    = (head_q == tail_q);
   assign full     = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
   assign enq_fire = enq_valid & enq_ready;

   // Distance from head decides liveness; rebuilding from head restores the tag's wrap bit.
   assign rs_dist  = restore_tag - head_q[PTR_W-1:0];
   assign rs_legal = ({1'b0, rs_dist} < occ);
   assign rs_ptr   = head_q + {1'b0, rs_dist};

   assign enq_ready      = ~full & ~restore_valid & ~flush_valid;
   assign enq_tag        = tail_q[PTR_W-1:0];
   assign occupancy      = occ;
   assign update_valid   = upd_v_q;
   assign update_ras_idx = upd_idx_q;
   assign update_ras_cnt = upd_cnt_q;
   assign err_sticky     = err_q;

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      upd_v_d   = 1'b0;
      upd_idx_d = upd_idx_q;
      upd_cnt_d = upd_cnt_q;
      err_d     = err_q;
      if (flush_valid) begin
         head_d = tail_q;
      end else begin
         if (deq_valid) begin
            if (empty) err_d  = 1'b1;
            else       head_d = head_q + PTR_ONE;
         end
         if (restore_valid) begin
            if (rs_legal) begin
               tail_d    = rs_ptr + PTR_ONE;
               upd_v_d   = 1'b1;
               upd_idx_d = idx_q[restore_tag];
               upd_cnt_d = cnt_q[restore_tag];
            end else begin
               err_d = 1'b1;
            end
         end
         if (enq_fire) tail_d = tail_q + PTR_ONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q    <= '0;
         tail_q    <= '0;
         upd_v_q   <= 1'b0;
         upd_idx_q <= '0;
         upd_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         upd_v_q   <= upd_v_d;
         upd_idx_q <= upd_idx_d;
         upd_cnt_q <= upd_cnt_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (enq_fire) begin
         idx_q[tail_q[PTR_W-1:0]] <= enq_ras_idx;
         cnt_q[tail_q[PTR_W-1:0]] <= enq_ras_cnt;
      end
   end

endmodule

// File: tb/tb_ras_restore_q.sv
// tb/tb_ras_restore_q.sv - scoreboard bench for ras_restore_q against a queue-based model
module tb_ras_restore_q;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       enq_valid = 1'b0;
   logic [2:0] enq_ras_idx = '0;
   logic [3:0] enq_ras_cnt = '0;
   logic       enq_ready;
   logic [3:0] enq_tag;
   logic       deq_valid = 1'b0;
   logic       restore_valid = 1'b0;
   logic [3:0] restore_tag = '0;
   logic       flush_valid = 1'b0;
   logic       update_valid;
   logic [2:0] update_ras_idx;
   logic [3:0] update_ras_cnt;
   logic [4:0] occupancy;
   logic       err_sticky;

   ras_restore_q dut (
      .CLK(CLK), .RST(RST),
      .enq_valid(enq_valid), .enq_ras_idx(enq_ras_idx), .enq_ras_cnt(enq_ras_cnt),
      .enq_ready(enq_ready), .enq_tag(enq_tag),
      .deq_valid(deq_valid), .restore_valid(restore_valid), .restore_tag(restore_tag),
      .flush_valid(flush_valid),
      .update_valid(update_valid), .update_ras_idx(update_ras_idx), .update_ras_cnt(update_ras_cnt),
      .occupancy(occupancy), .err_sticky(err_sticky)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] tag;
      logic [2:0] idx;
      logic [3:0] cnt;
   } ent_t;

   typedef struct {
      int         due;
      logic [2:0] idx;
      logic [3:0] cnt;
   } exp_t;

   ent_t       live[$];
   exp_t       sb[$];
   logic [3:0] next_tag = '0;
   bit         m_err = 1'b0;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   always @(posedge CLK) cyc = cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a restore update.
   always @(negedge CLK) begin
      if (!RST) begin
         chk("update_valid", int'(update_valid), int'(sb.size() > 0 && sb[0].due == cyc));
         if (update_valid && sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("update_data", int'({update_ras_idx, update_ras_cnt}), int'({e.idx, e.cnt}));
         end
         while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
      end
   end

   task automatic step(input bit e, input logic [2:0] ix, input logic [3:0] cn,
                       input bit d, input bit r, input logic [3:0] rt, input bit f);
      bit m_ready;
      int p, pre;
      enq_valid = e; enq_ras_idx = ix; enq_ras_cnt = cn;
      deq_valid = d; restore_valid = r; restore_tag = rt; flush_valid = f;
      #1;
      m_ready = (live.size() < 16) && !r && !f;
      chk("enq_ready", int'(enq_ready), int'(m_ready));
      chk("occupancy", int'(occupancy), live.size());
      chk("err_sticky", int'(err_sticky), int'(m_err));
      chk("enq_tag", int'(enq_tag), int'(next_tag));
      if (f) begin
         live.delete();
      end else begin
         pre = live.size();
         if (r) begin
            p = -1;
            foreach (live[i]) if (live[i].tag == rt) p = i;
            if (p >= 0) begin
               sb.push_back('{cyc + 1, live[p].idx, live[p].cnt});
               while (live.size() > p + 1) void'(live.pop_back());
               next_tag = rt + 4'd1;
            end else begin
               m_err = 1'b1;
            end
         end
         if (d) begin
            if (pre == 0) m_err = 1'b1;
            else          void'(live.pop_front());
         end
         if (e && m_ready) begin
            live.push_back('{next_tag, ix, cn});
            next_tag = next_tag + 4'd1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      step(0, '0, '0, 0, 0, '0, 0);
   endtask

   task automatic enq(input int i);
      step(1, 3'(i % 8), 4'(i), 0, 0, '0, 0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      enq_valid = 0; deq_valid = 0; restore_valid = 0; flush_valid = 0;
      live.delete(); sb.delete(); m_err = 1'b0; next_tag = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_occ", int'(occupancy), 0);
      chk("rst_ready", int'(enq_ready), 1);
      chk("rst_tag", int'(enq_tag), 0);
      chk("rst_err", int'(err_sticky), 0);

      // 1: reset mid-stream with 5 entries and a restore about to be clocked
      for (int i = 0; i < 5; i++) enq(i);
      restore_valid = 1'b1; restore_tag = 4'd2;
      #2;
      do_reset();
      @(posedge CLK); #1;
      chk("t1_occ", int'(occupancy), 0);
      chk("t1_ready", int'(enq_ready), 1);
      chk("t1_upd", int'(update_valid), 0);
      chk("t1_tag", int'(enq_tag), 0);

      // 2: fill, then deq+enq while full must reject the enq
      for (int i = 0; i < 16; i++) enq(i);
      chk("t2_full_ready", int'(enq_ready), 0);
      chk("t2_full_occ", int'(occupancy), 16);
      step(1, 3'd7, 4'd9, 1, 0, '0, 0);
      chk("t2_after_occ", int'(occupancy), 15);

      // 3: restore tag 2 out of 6 entries
      do_reset();
      for (int i = 0; i < 6; i++) enq(i);
      step(0, '0, '0, 0, 1, 4'd2, 0);
      chk("t3_occ", int'(occupancy), 3);
      chk("t3_tag", int'(enq_tag), 3);
      chk("t3_upd_idx", int'(update_ras_idx), 2);
      chk("t3_upd_cnt", int'(update_ras_cnt), 2);
      idle();

      // 4: wrap-around restore, then a squashed (illegal) tag
      do_reset();
      for (int i = 0; i < 14; i++) enq(i);
      for (int i = 0; i < 14; i++) step(0, '0, '0, 1, 0, '0, 0);
      for (int i = 0; i < 6; i++) enq(20 + i);
      step(0, '0, '0, 0, 1, 4'd1, 0);
      chk("t4_occ", int'(occupancy), 4);
      chk("t4_upd_cnt", int'(update_ras_cnt), 4'(23));
      step(0, '0, '0, 0, 1, 4'd5, 0);
      chk("t4_err", int'(err_sticky), 1);

      // 5: deq+restore of the retiring entry; flush+restore
      do_reset();
      for (int i = 0; i < 8; i++) enq(i);
      for (int i = 0; i < 7; i++) step(0, '0, '0, 1, 0, '0, 0);
      step(0, '0, '0, 1, 1, 4'd7, 0);
      chk("t5_occ", int'(occupancy), 0);
      chk("t5_upd_idx", int'(update_ras_idx), 7);
      for (int i = 0; i < 3; i++) enq(i);
      step(0, '0, '0, 1, 1, 4'd9, 1);
      chk("t5_flush_occ", int'(occupancy), 0);
      chk("t5_no_err", int'(err_sticky), 0);
      idle();

      // 6: deq on empty, then randomized traffic
      do_reset();
      step(0, '0, '0, 1, 0, '0, 0);
      chk("t6_err", int'(err_sticky), 1);
      chk("t6_occ", int'(occupancy), 0);
      chk("t6_tag", int'(enq_tag), 0);
      for (int n = 0; n < 10000; n++) begin
         bit e, d, r, f;
         logic [3:0] rt;
         if (n % 2500 == 2499) do_reset();
         e = ($urandom % 10) < 6;
         d = ($urandom % 10) < 3;
         r = ($urandom % 10) == 0;
         f = ($urandom % 50) == 0;
         if (live.size() > 0 && ($urandom % 4) != 0)
            rt = live[$urandom_range(0, live.size() - 1)].tag;
         else
            rt = 4'($urandom % 16);
         step(e, 3'($urandom), 4'($urandom), d, r, rt, f);
      end
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
